uart_rx: RTL and testbench

UART receiver, the receive-side counterpart of the team's uart_tx. It deserialises frames of the form start(0), 8 data bits LSB first, even parity bit, stop(1) from an asynchronous serial line, using an oversampling tick. Received bytes go to the host through a valid/ready handshake, with parity, framing and overrun error flags. It sits between the pad-side rx line and the host/FIFO logic.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_rx.sv | 152 +++++++++++++++
 tb/tb_uart_rx.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry, parity mode
// and the received-byte payload.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W      = 3;
  localparam int unsigned STATE_W        = 3;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } parity_mode_e;

  // The tx and rx sides must agree on this.
  localparam parity_mode_e PARITY_MODE = EVEN;

  typedef struct packed {
    logic [UART_DATA_BITS-1:0] data;
    logic                      parity_err;
    logic                      frame_err;
  } rx_byte_t;

endpackage

// File: rtl/uart_sync.sv
// Flop-chain synchroniser for an asynchronous level input; resets to 1
// (the idle level of a UART line).
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= '1;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, 8 data bits LSB first, parity, stop; oversampled
// mid-bit sampling with a valid/ready output holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable_clk,
  input  logic       rx,
  input  logic       rx_ready,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err
);

  localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic [STATE_W-1:0]        state, state_n;
  logic [TICK_W-1:0]         tick_cnt, tick_n;
  logic [BIT_CNT_W-1:0]      bit_cnt, bit_n;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_n;
  logic                      par_bad, par_n;
  rx_byte_t                  out_q, out_n;
  logic                      valid_n, ovr_n;
  logic                      frame_done_c;
  logic                      mid_c;

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

  assign mid_c = (tick_cnt == FULL_LAST);

  // Frame sequencing; everything advances only on oversample ticks.
  always_comb begin
    state_n      = state;
    tick_n       = tick_cnt;
    bit_n        = bit_cnt;
    shift_n      = shift_reg;
    par_n        = par_bad;
    frame_done_c = 1'b0;
    if (enable_clk) begin
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state_n = ST_START;
            tick_n  = '0;
          end
        end
        ST_START: begin
          if (tick_cnt == HALF_LAST) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? ST_IDLE : ST_DATA;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          if (mid_c) begin
            shift_n = {rx_s, shift_reg[UART_DATA_BITS-1:1]};
            tick_n  = '0;
            bit_n   = bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) state_n = ST_PARITY;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        ST_PARITY: begin
          if (mid_c) begin
            par_n   = rx_s ^ (^shift_reg) ^ (PARITY_MODE == ODD);
            tick_n  = '0;
            state_n = ST_STOP;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          if (mid_c) begin
            frame_done_c = 1'b1;
            tick_n       = '0;
            state_n      = rx_s ? ST_IDLE : ST_WAIT_HIGH;
          end else begin
            tick_n = tick_cnt + 1'b1;
          end
        end
        ST_WAIT_HIGH: begin
          if (rx_s) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Holding register: a completing frame may reuse the slot on the cycle it is accepted.
  always_comb begin
    out_n   = out_q;
    valid_n = rx_valid;
    ovr_n   = 1'b0;
    if (frame_done_c) begin
      if (!rx_valid || rx_ready) begin
        out_n.data       = shift_reg;
        out_n.parity_err = par_bad;
        out_n.frame_err  = ~rx_s;
        valid_n          = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_bad     <= 1'b0;
      out_q       <= '0;
      rx_valid    <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_n;
      bit_cnt     <= bit_n;
      shift_reg   <= shift_n;
      par_bad     <= par_n;
      out_q       <= out_n;
      rx_valid    <= valid_n;
      overrun_err <= ovr_n;
    end
  end

  assign data_out   = out_q.data;
  assign parity_err = out_q.parity_err;
  assign frame_err  = out_q.frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised bench for uart_rx: frames are scheduled arithmetically and a
// per-cycle model of the host-side outputs is compared with the DUT.
module tb_uart_rx;

  localparam int OS   = 16;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + OS / 2 + 10 * OS;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_clk;
  logic       rx;
  logic       rx_ready;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
  logic       overrun_err;

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_clk  (enable_clk),
    .rx          (rx),
    .rx_ready    (rx_ready),
    .data_out    (data_out),
    .rx_valid    (rx_valid),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .overrun_err (overrun_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t q[$];
  exp_t cur;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ready_mode = 0;
  int last_start = 0;
  int rise_cyc = 0;
  int rise_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] rise_data = '0;
  logic rise_perr = 1'b0, rise_ferr = 1'b0, prev_valid = 1'b0;

  logic       m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
  logic [7:0] m_data = '0;
  bit         done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    case (ready_mode)
      0:       rx_ready = 1'b1;
      1:       rx_ready = 1'b0;
      default: rx_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Host-side model plus per-cycle comparison.
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
      q.delete();
    end else begin
      done = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        done = 1'b1;
        cur  = q.pop_front();
      end
      m_ovr = 1'b0;
      if (done) begin
        if (!m_valid || rx_ready) begin
          m_valid = 1'b1; m_data = cur.data; m_perr = cur.perr; m_ferr = cur.ferr;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && rx_ready) begin
        m_valid = 1'b0;
      end
    end
    #1;
    chk("outputs", 32'({rx_valid, data_out, parity_err, frame_err, overrun_err}),
        32'({m_valid, m_data, m_perr, m_ferr, m_ovr}));
    if (rx_valid === 1'b1 && prev_valid !== 1'b1) begin
      rise_cyc = cyc; rise_cnt++;
      rise_data = data_out; rise_perr = parity_err; rise_ferr = frame_err;
    end
    prev_valid = rx_valid;
    if (overrun_err === 1'b1) ovr_cnt++;
  end

  // Called aligned to a negedge; holds level b for n clocks.
  task automatic hold(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit stop,
                            input int low_extra, input int rst_bit);
    logic [10:0] fr;
    exp_t e;
    last_start = cyc + 1;
    e.cyc  = last_start + LAT;
    e.data = d;
    e.perr = bad_par;
    e.ferr = ~stop;
    q.push_back(e);
    fr = {stop, (^d) ^ bad_par, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (i == rst_bit) begin
        rst = 1'b1;
        rx  = fr[i];
        @(negedge clk);
        rst = 1'b0;
        hold(fr[i], OS - 1);
      end else begin
        hold(fr[i], OS);
      end
    end
    if (!stop) hold(1'b0, low_extra);
    rx = 1'b1;
  endtask

  initial begin
    int ovr0, rise0;
    rst = 1'b1; rx = 1'b1; enable_clk = 1'b1; rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 32'd0);
    chk("reset_data", 32'(data_out), 32'h0);
    rst = 1'b0;
    hold(1'b1, 5);

    send_frame(8'hA5, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 4);
    chk("a5_data", 32'(rise_data), 32'hA5);
    chk("a5_flags", 32'({rise_perr, rise_ferr}), 32'd0);
    chk("a5_latency", 32'(rise_cyc - last_start), 32'd170);

    send_frame(8'h01, 1'b1, 1'b1, 0, -1);
    hold(1'b1, 4);
    chk("bad_par_data", 32'(rise_data), 32'h01);
    chk("bad_par_flags", 32'({rise_perr, rise_ferr}), 32'b10);

    send_frame(8'h3C, 1'b0, 1'b0, 40, -1);
    hold(1'b1, 6);
    chk("break_data", 32'(rise_data), 32'h3C);
    chk("break_flags", 32'({rise_perr, rise_ferr}), 32'b01);
    send_frame(8'h55, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 4);
    chk("after_break_data", 32'(rise_data), 32'h55);
    chk("after_break_flags", 32'({rise_perr, rise_ferr}), 32'b00);

    ready_mode = 1;
    ovr0 = ovr_cnt;
    hold(1'b1, 2);
    send_frame(8'h11, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 4);
    send_frame(8'h22, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 4);
    chk("overrun_hold_data", 32'(data_out), 32'h11);
    chk("overrun_hold_valid", 32'(rx_valid), 32'd1);
    chk("overrun_pulses", 32'(ovr_cnt - ovr0), 32'd1);
    ready_mode = 0;
    hold(1'b1, 3);
    chk("overrun_consumed", 32'(rx_valid), 32'd0);

    rise0 = rise_cnt;
    hold(1'b0, 4);
    hold(1'b1, OS + 4);
    chk("glitch_no_valid", 32'(rise_cnt - rise0), 32'd0);
    ready_mode = 1;
    hold(1'b1, 2);
    send_frame(8'hFF, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 4);
    chk("ff_data", 32'(data_out), 32'hFF);
    chk("ff_valid", 32'({rx_valid, parity_err, frame_err}), 32'b100);

    rise0 = rise_cnt;
    send_frame(8'h80, 1'b0, 1'b1, 0, 8);
    hold(1'b1, 4);
    chk("rst_mid_outputs", 32'({rx_valid, data_out, parity_err, frame_err, overrun_err}), 32'd0);
    chk("rst_mid_no_frame", 32'(rise_cnt - rise0), 32'd0);
    ready_mode = 0;
    hold(1'b1, 2);
    send_frame(8'h80, 1'b0, 1'b1, 0, -1);
    hold(1'b1, 4);
    chk("fresh_80_data", 32'(rise_data), 32'h80);

    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      send_frame(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                 int'($urandom_range(0, 30)), -1);
      hold(1'b1, int'($urandom_range(4, 12)));
    end
    ready_mode = 0;
    hold(1'b1, 20);
    chk("all_frames_delivered", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
